binary_mul_14_1_uni: RTL and testbench

//  Unsigned 14x14 -> 28-bit binary multiplier; fully pipelined, one partial-product bit per stage.

---
 rtl/binary_mul_pkg.sv | 23 ++
 rtl/binary_mul_stage.sv | 37 +++
 rtl/binary_mul_14_1_uni.sv | 71 +++++++
 tb/tb_binary_mul_14_1_uni.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/binary_mul_pkg.sv
// Shared constants, types and the shift-add helper for the pipelined
// unsigned binary multiplier.
//   WIDTH   : operand width
//   PROD_W  : product width (2*WIDTH)
//   LATENCY : enabled edges from operand sampling to product on P
package binary_mul_pkg;

  localparam int WIDTH   = 14;
  localparam int PROD_W  = 2 * WIDTH;
  localparam int LATENCY = WIDTH + 1;

  typedef logic [WIDTH-1:0]  operand_t;
  typedef logic [PROD_W-1:0] product_t;

  // Partial product contributed by one multiplier bit: the multiplicand
  // shifted to that bit's weight, or zero when the bit is clear.
  function automatic product_t partial_product(input operand_t a,
                                               input logic     sel,
                                               input int       shift);
    return sel ? (product_t'(a) << shift) : '0;
  endfunction

endpackage

// File: rtl/binary_mul_stage.sv
// One shift-add stage of the multiplier pipeline. Stage STAGE adds the
// partial product for multiplier bit STAGE-1 into the running sum and
// forwards both operands alongside it.
// Ports:
//   clk, rst_n, en : clock, async active-low reset, stage enable
//   a, b, acc      : operands and running sum from the previous stage
//   a_reg, b_reg   : registered operands for the next stage
//   acc_reg        : registered running sum
module binary_mul_stage
  import binary_mul_pkg::*;
#(
  parameter int STAGE = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     en,
  input  operand_t a,
  input  operand_t b,
  input  product_t acc,
  output operand_t a_reg,
  output operand_t b_reg,
  output product_t acc_reg
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg   <= '0;
      b_reg   <= '0;
      acc_reg <= '0;
    end else if (en) begin
      a_reg   <= a;
      b_reg   <= b;
      acc_reg <= acc + partial_product(a, b[STAGE-1], STAGE - 1);
    end
  end

endmodule

// File: rtl/binary_mul_14_1_uni.sv
// Fully pipelined unsigned 14x14 -> 28-bit multiplier. An input register
// (stage 0) captures A/B, then WIDTH shift-add stages each fold in one
// multiplier bit. The last stage's sum register drives P directly, so a
// product appears LATENCY enabled edges after its operands were sampled.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset, clears the whole pipeline
//   en    : pipeline enable; low freezes every register including P
//   A, B  : unsigned operands
//   P     : registered product A*B
module binary_mul_14_1_uni
  import binary_mul_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [WIDTH-1:0]  A,
  input  logic [WIDTH-1:0]  B,
  output logic [PROD_W-1:0] P
);

  operand_t a0_reg;
  operand_t b0_reg;

  // Stage outputs; element k holds the registers of stage k.
  operand_t a_pipe   [1:WIDTH];
  operand_t b_pipe   [1:WIDTH];
  product_t acc_pipe [1:WIDTH];

  // Stage 0: operand capture only, the running sum starts at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a0_reg <= '0;
      b0_reg <= '0;
    end else if (en) begin
      a0_reg <= A;
      b0_reg <= B;
    end
  end

  for (genvar gi = 1; gi <= WIDTH; gi++) begin : g_stage
    if (gi == 1) begin : g_first
      binary_mul_stage #(.STAGE(gi)) u_stage (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .a       (a0_reg),
        .b       (b0_reg),
        .acc     ('0),
        .a_reg   (a_pipe[gi]),
        .b_reg   (b_pipe[gi]),
        .acc_reg (acc_pipe[gi])
      );
    end else begin : g_rest
      binary_mul_stage #(.STAGE(gi)) u_stage (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .a       (a_pipe[gi-1]),
        .b       (b_pipe[gi-1]),
        .acc     (acc_pipe[gi-1]),
        .a_reg   (a_pipe[gi]),
        .b_reg   (b_pipe[gi]),
        .acc_reg (acc_pipe[gi])
      );
    end
  end

  assign P = acc_pipe[WIDTH];

endmodule

// File: tb/tb_binary_mul_14_1_uni.sv
// Scoreboard bench for binary_mul_14_1_uni. The driver pushes each
// expected product with the enabled-edge number at which it must be on P;
// the monitor counts enabled edges and compares when an entry falls due.
module tb_binary_mul_14_1_uni;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [13:0] A;
  logic [13:0] B;
  logic [27:0] P;

  typedef struct {
    logic [27:0] exp;
    int          due;
    string       name;
  } sb_entry_t;

  sb_entry_t sb_q[$];
  int        edge_cnt = 0;
  int        n_checks = 0;
  int        n_fail   = 0;

  binary_mul_14_1_uni dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .A     (A),
    .B     (B),
    .P     (P)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [27:0] act, input logic [27:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: P=%0d required %0d", name, act, exp);
    end
  endtask

  // Monitor: count enabled edges, compare the oldest due entry.
  always @(posedge clk) begin
    if (rst_n && en) begin
      edge_cnt++;
      #1;
      if (sb_q.size() > 0 && sb_q[0].due == edge_cnt) begin
        sb_entry_t e;
        e = sb_q.pop_front();
        $display("edge %0d %s: P=%0d expected %0d", edge_cnt, e.name, P, e.exp);
        check(e.name, P, e.exp);
      end
    end
  end

  // Present one pair for the next edge and schedule its product.
  task automatic drive(input logic [13:0] a, input logic [13:0] b, input string name);
    sb_entry_t e;
    @(negedge clk);
    A  = a;
    B  = b;
    en = 1'b1;
    e.exp  = 28'(a) * 28'(b);
    e.due  = edge_cnt + 15;
    e.name = name;
    sb_q.push_back(e);
  endtask

  // Release reset; P must stay 0 until the first fresh pair drains through.
  task automatic release_reset();
    sb_entry_t e;
    @(negedge clk);
    rst_n = 1'b1;
    A     = '0;
    B     = '0;
    en    = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      e.exp  = '0;
      e.due  = edge_cnt + i;
      e.name = "post_reset_zero";
      sb_q.push_back(e);
    end
  endtask

  task automatic hold_reset_check(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      A  = 14'h3FFF;
      B  = 14'h3FFF;
      en = 1'b1;
      check("in_reset", P, 28'd0);
    end
  endtask

  logic [27:0] frozen;

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    A     = 14'h3FFF;
    B     = 14'h3FFF;

    // Reset with max operands on the inputs.
    hold_reset_check(4);
    release_reset();

    // Isolated corners, each followed by idle zero pairs.
    drive(14'd0,     14'd0,     "corner_0x0");
    for (int i = 0; i < 14; i++) drive(14'd0, 14'd0, "idle");
    drive(14'd1,     14'd16383, "corner_1xmax");
    for (int i = 0; i < 14; i++) drive(14'd0, 14'd0, "idle");
    drive(14'd16383, 14'd1,     "corner_maxx1");
    for (int i = 0; i < 14; i++) drive(14'd0, 14'd0, "idle");
    drive(14'd16383, 14'd16383, "corner_maxxmax");
    for (int i = 0; i < 14; i++) drive(14'd0, 14'd0, "idle");
    drive(14'd8192,  14'd2,     "corner_8192x2");
    for (int i = 0; i < 14; i++) drive(14'd0, 14'd0, "idle");

    // Back-to-back stream.
    drive(14'd3,     14'd5,   "stream_3x5");
    drive(14'd100,   14'd200, "stream_100x200");
    drive(14'd16383, 14'd2,   "stream_maxx2");
    drive(14'd12345, 14'd6789, "stream_12345x6789");
    drive(14'd10922, 14'd5461, "stream_aaaax5555");
    drive(14'd1,     14'd8192, "stream_1x8192");

    // Stall mid-stream.
    drive(14'd7,     14'd9,     "pre_stall_7x9");
    drive(14'd255,   14'd255,   "pre_stall_255x255");
    drive(14'd4096,  14'd4095,  "pre_stall_4096x4095");
    drive(14'd999,   14'd1001,  "pre_stall_999x1001");
    @(negedge clk);
    en     = 1'b0;
    A      = 14'h1234;
    B      = 14'h0ABC;
    frozen = P;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stall_hold", P, frozen);
    end
    drive(14'd16000, 14'd3,     "post_stall_16000x3");
    drive(14'd11,    14'd13,    "post_stall_11x13");
    for (int i = 0; i < 14; i++) drive(14'd0, 14'd0, "idle");

    // Non-zero traffic, then reset 7 edges into a further stream.
    for (int i = 1; i <= 14; i++) drive(14'(i * 1000), 14'(i + 3), "fill");
    for (int i = 1; i <= 7; i++)  drive(14'(i * 321),  14'(i * 77), "doomed");
    @(negedge clk);
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    check("reset_midflight", P, 28'd0);
    hold_reset_check(3);
    release_reset();
    drive(14'd16383, 14'd16383, "fresh_maxxmax");
    drive(14'd42,    14'd43,    "fresh_42x43");
    for (int i = 0; i < 15; i++) drive(14'd0, 14'd0, "idle");

    // Drain without scheduling more, then confirm nothing was left.
    @(negedge clk);
    A  = '0;
    B  = '0;
    en = 1'b1;
    repeat (16) @(negedge clk);
    check("drain_empty", 28'(sb_q.size()), 28'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
